iob_native_rr_arbiter: RTL

- Shares one IOb-native slave (e.g. the tester `iob_uart` or a peripheral register bank) between N_MASTERS IOb-native requesters.
- Round-robin arbitration.
- A grant is held from request acceptance until the slave completes the transaction. For reads, completion is `rvalid`. For writes, completion is the `avalid`/`ready` handshake.
- Used in simulation wrappers and the SoC interconnect wherever several bus masters must reach a single-ported slave.

---
 rtl/iob_native_rr_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/iob_native_rr_arbiter.sv
// Round-robin arbiter sharing one IOb-native slave between N_MASTERS requesters.
// The grant is held from request acceptance until the slave completes (write: handshake, read: rvalid).
module iob_native_rr_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                           clk_i,
    input  logic                           cke_i,
    input  logic                           rst_i,
    input  logic [N_MASTERS-1:0]           m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]    m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]    m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb_i,
    output logic [N_MASTERS-1:0]           m_ready_o,
    output logic [N_MASTERS*DATA_W-1:0]    m_rdata_o,
    output logic [N_MASTERS-1:0]           m_rvalid_o,
    output logic                           s_avalid_o,
    output logic [ADDR_W-1:0]              s_addr_o,
    output logic [DATA_W-1:0]              s_wdata_o,
    output logic [DATA_W/8-1:0]            s_wstrb_o,
    input  logic                           s_ready_i,
    input  logic [DATA_W-1:0]              s_rdata_i,
    input  logic                           s_rvalid_i,
    output logic                           busy_o
);

    localparam int unsigned IdxW  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int unsigned StrbW = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]   last_q, last_d;

    logic [IdxW-1:0]   rr_pick;
    logic              rr_found;
    logic              lane_avalid;
    logic [ADDR_W-1:0] lane_addr;
    logic [DATA_W-1:0] lane_wdata;
    logic [StrbW-1:0]  lane_wstrb;

    // Search last+1, last+2, ... modulo N_MASTERS for the first requester.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        rr_pick  = '0;
        rr_found = 1'b0;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            idx = (int'(last_q) + i) % N_MASTERS;
            if (!rr_found && m_avalid_i[idx]) begin
                rr_pick  = IdxW'(idx);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        lane_avalid = 1'b0;
        lane_addr   = '0;
        lane_wdata  = '0;
        lane_wstrb  = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (gnt_q == IdxW'(k)) begin
                lane_avalid = m_avalid_i[k];
                lane_addr   = m_addr_i[k*ADDR_W +: ADDR_W];
                lane_wdata  = m_wdata_i[k*DATA_W +: DATA_W];
                lane_wstrb  = m_wstrb_i[k*StrbW +: StrbW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        s_avalid_o = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        m_ready_o  = '0;
        m_rvalid_o = '0;

        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    gnt_d   = rr_pick;
                    state_d = StReq;
                end
            end
            StReq: begin
                s_avalid_o       = lane_avalid;
                s_addr_o         = lane_addr;
                s_wdata_o        = lane_wdata;
                s_wstrb_o        = lane_wstrb;
                m_ready_o[gnt_q] = s_ready_i;
                if (lane_avalid && s_ready_i) begin
                    last_d  = gnt_q;
                    state_d = (lane_wstrb == '0) ? StWaitR : StIdle;
                end else if (!lane_avalid) begin
                    // Master withdrew before acceptance: release without moving priority.
                    state_d = StIdle;
                end
            end
            StWaitR: begin
                if (s_rvalid_i) begin
                    m_rvalid_o[gnt_q] = 1'b1;
                    state_d           = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are forced quiet while reset is held, even mid-transaction.
        if (rst_i) begin
            s_avalid_o = 1'b0;
            s_addr_o   = '0;
            s_wdata_o  = '0;
            s_wstrb_o  = '0;
            m_ready_o  = '0;
            m_rvalid_o = '0;
        end
    end

    assign m_rdata_o = rst_i ? '0 : {N_MASTERS{s_rdata_i}};
    assign busy_o    = !rst_i && (state_q != StIdle);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            last_q  <= IdxW'(N_MASTERS - 1);
        end else if (cke_i) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

endmodule
